// File: rtl/text_console_ctrl.sv
// ---------------------------------------------------------------------------
// text_console_ctrl
//
// Write-side sequencer for the text-console dual-port video RAM. Accepts a
// byte stream (valid/ready), interprets printable and control codes, and
// drives the RAM write port. Tracks the cursor, wraps lines, clears the
// screen, handles backspace, and scrolls in hardware: instead of moving RAM
// contents, the physical row shown as screen row 0 (top_row) advances and
// only the newly exposed bottom row is blanked.
//
// Ports
//   clk         clock for the whole block
//   resetn      asynchronous reset, active low
//   char_in     character or control code
//   char_valid  char_in is valid
//   char_ready  block can accept (transfer on valid && ready)
//   wr_data     RAM write data
//   wr_en       RAM write enable (at most one write per cycle)
//   wr_addr     RAM write address = phys_row*COLS + col
//   top_row     physical RAM row displayed as screen row 0
//   cursor_col  logical cursor column
//   cursor_row  logical cursor row (0 = top of screen)
//   busy        high while clearing or scrolling
//
// Every output is a register. A write caused by an accepted byte shows up
// on wr_* in the cycle after the accept and lasts one cycle.
// ---------------------------------------------------------------------------
module text_console_ctrl #(
  parameter int                    COLS           = 40,
  parameter int                    ROWS           = 30,
  parameter int                    ADDR_WIDTH     = $clog2(ROWS*COLS),
  parameter int                    DATA_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0] SPACE_CHAR     = DATA_WIDTH'(8'h20),
  parameter bit                    CLEAR_ON_RESET = 1'b1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [DATA_WIDTH-1:0]     char_in,
  input  logic                      char_valid,
  output logic                      char_ready,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      wr_en,
  output logic [ADDR_WIDTH-1:0]     wr_addr,
  output logic [$clog2(ROWS)-1:0]   top_row,
  output logic [$clog2(COLS)-1:0]   cursor_col,
  output logic [$clog2(ROWS)-1:0]   cursor_row,
  output logic                      busy
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int TOTAL = ROWS * COLS;
  // One extra count beyond the last address marks "sequence finished".
  localparam int CNT_W = $clog2(TOTAL + 1);

  localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [ROW_W:0]        ROWS_W    = (ROW_W + 1)'(ROWS);
  localparam logic [ADDR_WIDTH-1:0] COLS_A    = ADDR_WIDTH'(COLS);
  localparam logic [CNT_W-1:0]      CNT_TOTAL = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0]      CNT_COLS  = CNT_W'(COLS);

  localparam logic [DATA_WIDTH-1:0] C_BS    = DATA_WIDTH'(8'h08);
  localparam logic [DATA_WIDTH-1:0] C_LF    = DATA_WIDTH'(8'h0A);
  localparam logic [DATA_WIDTH-1:0] C_FF    = DATA_WIDTH'(8'h0C);
  localparam logic [DATA_WIDTH-1:0] C_CR    = DATA_WIDTH'(8'h0D);
  localparam logic [DATA_WIDTH-1:0] C_FIRST = DATA_WIDTH'(8'h20);
  localparam logic [DATA_WIDTH-1:0] C_LAST  = DATA_WIDTH'(8'h7E);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_SCROLL
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  state_t                  state, nxt_state;
  logic [CNT_W-1:0]        cnt, nxt_cnt;
  logic [ADDR_WIDTH-1:0]   scroll_base, nxt_scroll_base;
  logic [COL_W-1:0]        nxt_col;
  logic [ROW_W-1:0]        nxt_row, nxt_top;
  logic                    nxt_wr_en;
  logic [DATA_WIDTH-1:0]   nxt_wr_data;
  logic [ADDR_WIDTH-1:0]   nxt_wr_addr;
  logic                    newline;

  // Physical row under the cursor: (top_row + cursor_row) mod ROWS. Both
  // operands are below ROWS, so one conditional subtract is enough.
  logic [ROW_W:0]          row_sum;
  logic [ROW_W-1:0]        phys_row;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [ADDR_WIDTH-1:0]   top_base;

  assign row_sum  = {1'b0, top_row} + {1'b0, cursor_row};
  assign phys_row = (row_sum >= ROWS_W) ? ROW_W'(row_sum - ROWS_W) : row_sum[ROW_W-1:0];
  assign cur_addr = ADDR_WIDTH'(phys_row) * COLS_A + ADDR_WIDTH'(cursor_col);
  // The current top row becomes the new bottom row when the screen scrolls.
  assign top_base = ADDR_WIDTH'(top_row) * COLS_A;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    nxt_state       = state;
    nxt_cnt         = cnt;
    nxt_scroll_base = scroll_base;
    nxt_col         = cursor_col;
    nxt_row         = cursor_row;
    nxt_top         = top_row;
    nxt_wr_en       = 1'b0;
    nxt_wr_data     = wr_data;
    nxt_wr_addr     = wr_addr;
    newline         = 1'b0;

    case (state)
      S_IDLE: begin
        if (char_valid && char_ready) begin
          if (char_in >= C_FIRST && char_in <= C_LAST) begin
            nxt_wr_en   = 1'b1;
            nxt_wr_data = char_in;
            nxt_wr_addr = cur_addr;
            if (cursor_col == LAST_COL) begin
              nxt_col = '0;
              newline = 1'b1;
            end else begin
              nxt_col = cursor_col + 1'b1;
            end
          end else begin
            case (char_in)
              C_LF: newline = 1'b1;
              C_CR: nxt_col = '0;
              C_BS: begin
                // The erased cell is on the cursor's row, one address lower.
                if (cursor_col != '0) begin
                  nxt_col     = cursor_col - 1'b1;
                  nxt_wr_en   = 1'b1;
                  nxt_wr_data = SPACE_CHAR;
                  nxt_wr_addr = cur_addr - 1'b1;
                end
              end
              C_FF: begin
                // First blank is written in the accept cycle so the last one
                // lands while ready is still low.
                nxt_state   = S_CLEAR;
                nxt_col     = '0;
                nxt_row     = '0;
                nxt_top     = '0;
                nxt_wr_en   = 1'b1;
                nxt_wr_data = SPACE_CHAR;
                nxt_wr_addr = '0;
                nxt_cnt     = CNT_W'(1);
              end
              default: ; // other codes are consumed without effect
            endcase
          end
        end
      end

      S_CLEAR: begin
        if (cnt == CNT_TOTAL) begin
          nxt_state = S_IDLE;
          nxt_cnt   = '0;
        end else begin
          nxt_wr_en   = 1'b1;
          nxt_wr_data = SPACE_CHAR;
          nxt_wr_addr = ADDR_WIDTH'(cnt);
          nxt_cnt     = cnt + 1'b1;
        end
      end

      S_SCROLL: begin
        if (cnt == CNT_COLS) begin
          nxt_state = S_IDLE;
          nxt_cnt   = '0;
        end else begin
          nxt_wr_en   = 1'b1;
          nxt_wr_data = SPACE_CHAR;
          nxt_wr_addr = scroll_base + ADDR_WIDTH'(cnt);
          nxt_cnt     = cnt + 1'b1;
        end
      end

      default: nxt_state = S_IDLE;
    endcase

    if (newline) begin
      if (cursor_row != LAST_ROW) begin
        nxt_row = cursor_row + 1'b1;
      end else begin
        nxt_top         = (top_row == LAST_ROW) ? '0 : top_row + 1'b1;
        nxt_scroll_base = top_base;
        nxt_state       = S_SCROLL;
        if (nxt_wr_en) begin
          // The wrapping character owns this cycle's write; blanking starts
          // with the first cell next cycle.
          nxt_cnt = '0;
        end else begin
          nxt_wr_en   = 1'b1;
          nxt_wr_data = SPACE_CHAR;
          nxt_wr_addr = top_base;
          nxt_cnt     = CNT_W'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= RESET_STATE;
      cnt         <= '0;
      scroll_base <= '0;
      cursor_col  <= '0;
      cursor_row  <= '0;
      top_row     <= '0;
      wr_en       <= 1'b0;
      wr_data     <= '0;
      wr_addr     <= '0;
      char_ready  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      scroll_base <= nxt_scroll_base;
      cursor_col  <= nxt_col;
      cursor_row  <= nxt_row;
      top_row     <= nxt_top;
      wr_en       <= nxt_wr_en;
      wr_data     <= nxt_wr_data;
      wr_addr     <= nxt_wr_addr;
      // Registered from the next state so they track the state register.
      char_ready  <= (nxt_state == S_IDLE);
      busy        <= (nxt_state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
// ---------------------------------------------------------------------------
// tb_text_console_ctrl
//
// Bench for text_console_ctrl (COLS=40, ROWS=30). A transaction-level model
// turns each accepted byte into the list of per-cycle RAM writes and ready
// levels it must produce, plus the cursor/top-row state; a negedge process
// compares the DUT against it every cycle. Directed literal checks pin the
// model. A second instance with clear-on-reset exercises reset mid-clear.
// ---------------------------------------------------------------------------
module tb_text_console_ctrl;

  localparam int COLS = 40;
  localparam int ROWS = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance without clear-on-reset (model-checked).
  logic        resetn = 1'b0;
  logic [7:0]  char_in = '0;
  logic        char_valid = 1'b0;
  logic        char_ready, wr_en, busy;
  logic [7:0]  wr_data;
  logic [10:0] wr_addr;
  logic [4:0]  top_row, cursor_row;
  logic [5:0]  cursor_col;

  // Instance with clear-on-reset.
  logic        resetn_b = 1'b0;
  logic [7:0]  char_in_b = '0;
  logic        char_valid_b = 1'b0;
  logic        char_ready_b, wr_en_b, busy_b;
  logic [7:0]  wr_data_b;
  logic [10:0] wr_addr_b;
  logic [4:0]  top_row_b, cursor_row_b;
  logic [5:0]  cursor_col_b;

  text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .CLEAR_ON_RESET(1'b0)) dut (
    .clk(clk), .resetn(resetn), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .wr_data(wr_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .top_row(top_row), .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .CLEAR_ON_RESET(1'b1)) dut_cor (
    .clk(clk), .resetn(resetn_b), .char_in(char_in_b), .char_valid(char_valid_b),
    .char_ready(char_ready_b), .wr_data(wr_data_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
    .top_row(top_row_b), .cursor_col(cursor_col_b), .cursor_row(cursor_row_b), .busy(busy_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    bit we;
    int addr;
    int data;
    bit rdy;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_e;
  int   m_col = 0, m_row = 0, m_top = 0;
  bit   checking = 1'b0;

  function automatic void push(bit we, int addr, int data, bit rdy);
    exp_t e;
    e.we = we; e.addr = addr; e.data = data; e.rdy = rdy;
    exp_q.push_back(e);
  endfunction

  function automatic void model_newline();
    if (m_row < ROWS - 1) begin
      m_row++;
    end else begin
      int base;
      base  = m_top * COLS;            // old top row becomes the new bottom row
      m_top = (m_top + 1) % ROWS;
      for (int i = 0; i < COLS; i++) push(1'b1, base + i, 'h20, 1'b0);
    end
  endfunction

  function automatic void model_accept(int ch);
    int  addr;
    bit  wraps, scrolls;
    addr = ((m_top + m_row) % ROWS) * COLS + m_col;
    if (ch >= 'h20 && ch <= 'h7E) begin
      wraps   = (m_col == COLS - 1);
      scrolls = wraps && (m_row == ROWS - 1);
      push(1'b1, addr, ch, !scrolls);
      if (wraps) begin
        m_col = 0;
        model_newline();
      end else begin
        m_col++;
      end
    end else if (ch == 'h0A) begin
      model_newline();
    end else if (ch == 'h0D) begin
      m_col = 0;
    end else if (ch == 'h08) begin
      if (m_col > 0) begin
        m_col--;
        push(1'b1, addr - 1, 'h20, 1'b1);
      end
    end else if (ch == 'h0C) begin
      m_col = 0; m_row = 0; m_top = 0;
      for (int i = 0; i < ROWS * COLS; i++) push(1'b1, i, 'h20, 1'b0);
    end
  endfunction

  // Per-cycle compare; queue empty means idle: no write, ready high.
  always @(negedge clk) begin
    if (checking) begin
      if (exp_q.size() > 0) begin
        cur_e = exp_q.pop_front();
      end else begin
        cur_e.we = 1'b0; cur_e.addr = 0; cur_e.data = 0; cur_e.rdy = 1'b1;
      end
      check("wr_en", 32'(wr_en), 32'(cur_e.we));
      if (cur_e.we) begin
        check("wr_addr", 32'(wr_addr), cur_e.addr);
        check("wr_data", 32'(wr_data), cur_e.data);
      end
      check("char_ready", 32'(char_ready), 32'(cur_e.rdy));
      check("busy", 32'(busy), 32'(!cur_e.rdy));
      check("cursor_col", 32'(cursor_col), m_col);
      check("cursor_row", 32'(cursor_row), m_row);
      check("top_row", 32'(top_row), m_top);
      if (char_valid && char_ready) model_accept(32'(char_in));
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [7:0] ch);
    int waited;
    waited = 0;
    @(posedge clk); #1;
    char_in    = ch;
    char_valid = 1'b1;
    @(negedge clk);
    while (!char_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!char_ready) begin
      check("send_timeout", 32'(char_ready), 1);
      char_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      char_valid = 1'b0;
    end
  endtask

  task automatic send_b(input logic [7:0] ch);
    int waited;
    waited = 0;
    @(posedge clk); #1;
    char_in_b    = ch;
    char_valid_b = 1'b1;
    @(negedge clk);
    while (!char_ready_b && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!char_ready_b) check("send_b_timeout", 32'(char_ready_b), 1);
    else begin
      @(posedge clk); #1;
    end
    char_valid_b = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    checking   = 1'b0;
    resetn     = 1'b0;
    char_valid = 1'b0;
    exp_q.delete();
    m_col = 0; m_row = 0; m_top = 0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    checking = 1'b1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!char_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(char_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int low, writes;

    // Reset values on both instances.
    repeat (2) @(negedge clk);
    check("rst wr_en",    32'(wr_en), 0);
    check("rst wr_data",  32'(wr_data), 0);
    check("rst wr_addr",  32'(wr_addr), 0);
    check("rst top_row",  32'(top_row), 0);
    check("rst cursor",   32'({cursor_row, cursor_col}), 0);
    check("rst busy",     32'(busy), 0);
    check("rst ready",    32'(char_ready), 0);
    check("rst_b wr_en",  32'(wr_en_b), 0);
    check("rst_b busy",   32'(busy_b), 0);
    check("rst_b ready",  32'(char_ready_b), 0);
    resetn = 1'b1;
    @(posedge clk); #1;
    checking = 1'b1;

    // 1: single printable.
    send(8'h41);
    @(negedge clk);
    check("t1 wr_en", 32'(wr_en), 1);
    check("t1 addr",  32'(wr_addr), 0);
    check("t1 data",  32'(wr_data), 'h41);
    check("t1 col",   32'(cursor_col), 1);
    check("t1 row",   32'(cursor_row), 0);

    // 2: line wrap after 40 characters.
    reset_dut();
    for (int i = 0; i < 41; i++) begin
      send(8'h41);
      if (i == 39) begin
        @(negedge clk);
        check("t2 addr39", 32'(wr_addr), 39);
        check("t2 row",    32'(cursor_row), 1);
        check("t2 col",    32'(cursor_col), 0);
      end
      if (i == 40) begin
        @(negedge clk);
        check("t2 addr40", 32'(wr_addr), 40);
      end
    end

    // 3: bottom row, then scroll.
    reset_dut();
    repeat (29) send(8'h0A);
    send(8'h42);
    @(negedge clk);
    check("t3 B addr", 32'(wr_addr), 1160);
    check("t3 B data", 32'(wr_data), 'h42);
    send(8'h0A);
    low = 0; writes = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (char_ready) break;
      low++;
      if (wr_en) writes++;
    end
    check("t3 ready low cycles", low, 40);
    check("t3 scroll writes", writes, 40);
    check("t3 top_row", 32'(top_row), 1);
    send(8'h0D);
    send(8'h43);
    @(negedge clk);
    check("t3 C addr", 32'(wr_addr), 0);
    check("t3 C data", 32'(wr_data), 'h43);
    // Ignored codes: consumed, no write (model-checked).
    send(8'h09);
    send(8'h80);
    send(8'h7F);

    // 4: form feed clears the whole screen.
    send(8'h0C);
    low = 0; writes = 0;
    for (int k = 0; k < 1300; k++) begin
      @(negedge clk);
      if (!busy) break;
      low++;
      if (wr_en) writes++;
    end
    check("t4 busy cycles", low, 1200);
    check("t4 clear writes", writes, 1200);
    check("t4 cursor", 32'({cursor_row, cursor_col}), 0);
    check("t4 top_row", 32'(top_row), 0);
    check("t4 ready", 32'(char_ready), 1);
    // Byte offered while clearing is held off, then written at the origin.
    send(8'h0C);
    send(8'h44);
    @(negedge clk);
    check("t4 D addr", 32'(wr_addr), 0);
    check("t4 D data", 32'(wr_data), 'h44);

    // 5: backspace.
    reset_dut();
    send(8'h08);
    @(negedge clk);
    check("t5 bs col0 no write", 32'(wr_en), 0);
    send(8'h41);
    send(8'h42);
    send(8'h08);
    @(negedge clk);
    check("t5 bs wr_en", 32'(wr_en), 1);
    check("t5 bs addr",  32'(wr_addr), 1);
    check("t5 bs data",  32'(wr_data), 'h20);
    check("t5 bs col",   32'(cursor_col), 1);

    // Printable at bottom-right writes first, then scrolls; top_row wraps.
    reset_dut();
    repeat (29) send(8'h0A);
    repeat (40) send(8'h45);
    @(negedge clk);
    check("t7 last addr", 32'(wr_addr), 1199);
    check("t7 last data", 32'(wr_data), 'h45);
    wait_ready("t7 ready");
    check("t7 top_row", 32'(top_row), 1);
    check("t7 cursor", 32'({cursor_row, cursor_col}), 32'({5'd29, 6'd0}));
    repeat (29) send(8'h0A);
    wait_ready("t7 ready2");
    check("t7 top wrap", 32'(top_row), 0);

    // 6: clear-on-reset, aborted by reset at address 500.
    @(negedge clk);
    resetn_b = 1'b1;
    for (int i = 0; i <= 500; i++) begin
      @(negedge clk);
      check("t6 wr_en", 32'(wr_en_b), 1);
      check("t6 addr",  32'(wr_addr_b), i);
    end
    resetn_b = 1'b0;
    #1;
    check("t6 abort wr_en", 32'(wr_en_b), 0);
    check("t6 abort busy",  32'(busy_b), 0);
    @(negedge clk);
    @(negedge clk);
    resetn_b = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      check("t6r wr_en", 32'(wr_en_b), 1);
      check("t6r addr",  32'(wr_addr_b), i);
      check("t6r data",  32'(wr_data_b), 'h20);
      check("t6r busy",  32'(busy_b), 1);
    end
    @(negedge clk);
    check("t6 done ready", 32'(char_ready_b), 1);
    check("t6 done wr_en", 32'(wr_en_b), 0);
    check("t6 done busy",  32'(busy_b), 0);
    send_b(8'h07);
    @(negedge clk);
    check("t6 bel no write", 32'(wr_en_b), 0);
    check("t6 bel ready",    32'(char_ready_b), 1);
    send_b(8'h7F);
    @(negedge clk);
    check("t6 del no write", 32'(wr_en_b), 0);
    check("t6 del ready",    32'(char_ready_b), 1);
    check("t6 cursor", 32'({cursor_row_b, cursor_col_b}), 0);

    repeat (2) @(negedge clk);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
